// File: rtl/cycle_stim_sequencer.sv
// Stimulus sequencer: base-cycle prescaler, saturating base-cycle counter and a
// programmable (delay, value) schedule that drives active-low control lines.
module cycle_stim_sequencer #(
    parameter int                 CLK_DIV    = 8,
    parameter int                 NUM_CH     = 3,
    parameter int                 DEPTH      = 8,
    parameter int                 DELTA_W    = 16,
    parameter int                 CNT_W      = 32,
    parameter logic [NUM_CH-1:0]  INIT_LEVEL = '1,
    localparam int                AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [DELTA_W-1:0]  cfg_delta,
    input  logic [NUM_CH-1:0]   cfg_value,
    input  logic                cfg_last,
    input  logic                start,
    input  logic                abort,
    output logic [NUM_CH-1:0]   ctrl_out,
    output logic                base_tick,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                busy,
    output logic                done
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [PW-1:0]       presc_r;
    logic                tick_s;
    logic [AW-1:0]       ptr_r, ptr_next_s, ptr_inc_s;
    logic [DELTA_W-1:0]  rem_r, rem_next_s;
    logic [NUM_CH-1:0]   ctrl_r, ctrl_next_s;
    logic                busy_r, busy_next_s;
    logic                done_r, done_next_s;
    logic                tick_r;
    logic [CNT_W-1:0]    count_r;
    logic                entry_due_s, entry_final_s;

    logic [DELTA_W-1:0]  tbl_delta_r [DEPTH];
    logic [NUM_CH-1:0]   tbl_value_r [DEPTH];
    logic                tbl_last_r  [DEPTH];

    // tick_s marks the edge on which base_tick rises and the count advances
    assign tick_s        = (presc_r == PW'(CLK_DIV - 1));
    assign ptr_inc_s     = ptr_r + AW'(1);
    assign entry_due_s   = (rem_r == {DELTA_W{1'b0}});
    assign entry_final_s = tbl_last_r[ptr_r] || (ptr_r == AW'(DEPTH - 1));

    // Free-running prescaler, base tick and saturating base-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            presc_r <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
            tick_r  <= tick_s;
            if (tick_s && (count_r != {CNT_W{1'b1}})) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    // Schedule table; writes are locked out while a playback is running
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_delta_r[i] <= {DELTA_W{1'b0}};
                tbl_value_r[i] <= INIT_LEVEL;
                tbl_last_r[i]  <= 1'b1;
            end
        end else if (cfg_we && (state_r != ST_RUN)) begin
            tbl_delta_r[cfg_addr] <= cfg_delta;
            tbl_value_r[cfg_addr] <= cfg_value;
            tbl_last_r[cfg_addr]  <= cfg_last;
        end
    end

    // State and playback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ptr_r   <= {AW{1'b0}};
            rem_r   <= {DELTA_W{1'b0}};
            ctrl_r  <= INIT_LEVEL;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
            rem_r   <= rem_next_s;
            ctrl_r  <= ctrl_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state decode; abort dominates start
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_RUN: begin
                    if (entry_due_s && entry_final_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Playback datapath and next values of the registered outputs
    always_comb begin
        ptr_next_s  = ptr_r;
        rem_next_s  = rem_r;
        ctrl_next_s = ctrl_r;
        busy_next_s = busy_r;
        done_next_s = done_r;
        if (abort) begin
            ctrl_next_s = INIT_LEVEL;
            busy_next_s = 1'b0;
            done_next_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        ptr_next_s  = {AW{1'b0}};
                        rem_next_s  = tbl_delta_r[0];
                        busy_next_s = 1'b1;
                        done_next_s = 1'b0;
                    end else begin
                        busy_next_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (entry_due_s) begin
                        ctrl_next_s = tbl_value_r[ptr_r];
                        if (entry_final_s) begin
                            busy_next_s = 1'b0;
                            done_next_s = 1'b1;
                        end else begin
                            ptr_next_s = ptr_inc_s;
                            rem_next_s = tbl_delta_r[ptr_inc_s];
                        end
                    end else if (tick_s) begin
                        rem_next_s = rem_r - DELTA_W'(1);
                    end else begin
                        rem_next_s = rem_r;
                    end
                end
                default: begin
                    ctrl_next_s = INIT_LEVEL;
                    busy_next_s = 1'b0;
                    done_next_s = 1'b0;
                end
            endcase
        end
    end

    assign ctrl_out    = ctrl_r;
    assign base_tick   = tick_r;
    assign cycle_count = count_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_cycle_stim_sequencer.sv
// Scoreboard bench for cycle_stim_sequencer: expected control-line events are
// queued when a schedule is started and popped as ctrl_out changes.
module tb_cycle_stim_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [15:0] cfg_delta = 16'd0;
    logic [2:0]  cfg_value = 3'd0;
    logic        cfg_last = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  ctrl_out;
    logic        base_tick;
    logic [31:0] cycle_count;
    logic        busy;
    logic        done;

    logic [2:0]  sat_ctrl_out;
    logic        sat_base_tick;
    logic [3:0]  sat_cycle_count;
    logic        sat_busy;
    logic        sat_done;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [2:0] val;
        int         ticks;
        int         off;
        bit         prev_tick;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    cycle_stim_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_delta(cfg_delta), .cfg_value(cfg_value), .cfg_last(cfg_last),
        .start(start), .abort(abort), .ctrl_out(ctrl_out),
        .base_tick(base_tick), .cycle_count(cycle_count), .busy(busy), .done(done)
    );

    cycle_stim_sequencer #(.CLK_DIV(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .cfg_we(1'b0), .cfg_addr(3'd0),
        .cfg_delta(16'd0), .cfg_value(3'd0), .cfg_last(1'b0),
        .start(1'b0), .abort(1'b0), .ctrl_out(sat_ctrl_out),
        .base_tick(sat_base_tick), .cycle_count(sat_cycle_count),
        .busy(sat_busy), .done(sat_done)
    );

    task automatic cfg_write(input int addr, input int delta, input int value, input bit last);
        cfg_we    = 1'b1;
        cfg_addr  = addr[2:0];
        cfg_delta = delta[15:0];
        cfg_value = value[2:0];
        cfg_last  = last;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic push(input int val, input int ticks, input int off, input bit prev_tick);
        sb_t e;
        e.val = val[2:0];
        e.ticks = ticks;
        e.off = off;
        e.prev_tick = prev_tick;
        sb.push_back(e);
    endtask

    task automatic load_script();
        cfg_write(0, 2,  3'b110, 1'b0);
        cfg_write(1, 70, 3'b010, 1'b0);
        cfg_write(2, 40, 3'b110, 1'b0);
        cfg_write(3, 10, 3'b010, 1'b1);
    endtask

    task automatic push_script();
        push(3'b110, 2,   -1, 1'b1);
        push(3'b010, 72,  -1, 1'b1);
        push(3'b110, 112, -1, 1'b1);
        push(3'b010, 122, -1, 1'b1);
    endtask

    // Called on the negedge right after the start edge; drains the scoreboard.
    task automatic run_check(input string name, input int budget);
        int ticks = 0;
        int off = 1;
        int guard = 0;
        logic [2:0] last_val = ctrl_out;
        bit prev = base_tick;
        sb_t e;
        while (sb.size() > 0 && guard < budget) begin
            @(negedge clk);
            off++;
            guard++;
            if (base_tick) ticks++;
            if (ctrl_out !== last_val) begin
                e = sb.pop_front();
                checks++;
                if (ctrl_out !== e.val || (e.ticks >= 0 && ticks != e.ticks) ||
                    (e.off >= 0 && off != e.off) || (e.prev_tick && !prev)) begin
                    $display("FAIL %s event: ctrl=%b ticks=%0d clk=%0d prevtick=%0d, want ctrl=%b ticks=%0d clk=%0d prevtick=%0d",
                             name, ctrl_out, ticks, off, prev, e.val, e.ticks, e.off, e.prev_tick);
                end else begin
                    passed++;
                end
            end
            last_val = ctrl_out;
            prev = base_tick;
        end
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL %s timeout: %0d events pending after %0d clks, want 0", name, sb.size(), guard);
            sb.delete();
        end else if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL %s end: done=%b busy=%b, want done=1 busy=0", name, done, busy);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ctrl_out !== 3'b111 || base_tick !== 1'b0 || cycle_count !== 32'd0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_values: ctrl=%b tick=%b cnt=%0d busy=%b done=%b, want 111 0 0 0 0",
                     ctrl_out, base_tick, cycle_count, busy, done);
        end else begin
            passed++;
        end
        rst = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            checks++;
            if (base_tick !== ((k % 8) == 0)) begin
                $display("FAIL base_tick clk %0d: got %b, want %0d", k, base_tick, (k % 8) == 0);
            end else begin
                passed++;
            end
            if (k == 10) begin
                checks++;
                if (sat_cycle_count !== 4'd5) begin
                    $display("FAIL sat_count_early: got %0d, want 5", sat_cycle_count);
                end else begin
                    passed++;
                end
            end
        end
        checks++;
        if (cycle_count !== 32'd10 || ctrl_out !== 3'b111) begin
            $display("FAIL count_80: cnt=%0d ctrl=%b, want 10 111", cycle_count, ctrl_out);
        end else begin
            passed++;
        end
    endtask

    task automatic test_three_switch();
        load_script();
        push_script();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL script_busy: busy=%b done=%b, want 1 0", busy, done);
        end else begin
            passed++;
        end
        run_check("three_switch", 2000);
        repeat (20) @(negedge clk);
        checks++;
        if (done !== 1'b1 || ctrl_out !== 3'b010) begin
            $display("FAIL done_sticky: done=%b ctrl=%b, want 1 010", done, ctrl_out);
        end else begin
            passed++;
        end
    endtask

    task automatic test_zero_deltas();
        pulse_abort();
        for (int i = 0; i < 4; i++) cfg_write(i, 0, i + 1, i == 3);
        for (int i = 0; i < 4; i++) push(i + 1, -1, i + 2, 1'b0);
        pulse_start();
        run_check("zero_deltas", 50);
    endtask

    task automatic test_abort();
        int ticks = 0;
        int guard = 0;
        pulse_abort();
        load_script();
        pulse_start();
        while (ticks < 52 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (base_tick) ticks++;
        end
        checks++;
        if (ticks != 52 || ctrl_out !== 3'b110 || busy !== 1'b1) begin
            $display("FAIL abort_pre: ticks=%0d ctrl=%b busy=%b, want 52 110 1", ticks, ctrl_out, busy);
        end else begin
            passed++;
        end
        pulse_abort();
        checks++;
        if (ctrl_out !== 3'b111 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL abort_post: ctrl=%b busy=%b done=%b, want 111 0 0", ctrl_out, busy, done);
        end else begin
            passed++;
        end
        repeat (5) @(negedge clk);
        push_script();
        pulse_start();
        run_check("abort_replay", 2000);
    endtask

    task automatic test_table_full();
        pulse_abort();
        for (int i = 0; i < 8; i++) cfg_write(i, 1, i, 1'b0);
        for (int i = 0; i < 8; i++) push(i, i + 1, -1, 1'b1);
        pulse_start();
        fork
            run_check("table_full", 300);
            begin
                repeat (20) @(negedge clk);
                cfg_write(5, 0, 3'b111, 1'b1);
            end
        join
        for (int i = 0; i < 8; i++) push(i, i + 1, -1, 1'b1);
        pulse_start();
        run_check("table_replay", 300);
    endtask

    task automatic test_start_abort_idle();
        pulse_abort();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ctrl_out !== 3'b111) begin
            $display("FAIL start_abort: busy=%b done=%b ctrl=%b, want 0 0 111", busy, done, ctrl_out);
        end else begin
            passed++;
        end
    endtask

    task automatic test_rst_mid();
        load_script();
        pulse_start();
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ctrl_out !== 3'b111 || busy !== 1'b0 || done !== 1'b0 ||
            base_tick !== 1'b0 || cycle_count !== 32'd0) begin
            $display("FAIL rst_mid: ctrl=%b busy=%b done=%b tick=%b cnt=%0d, want 111 0 0 0 0",
                     ctrl_out, busy, done, base_tick, cycle_count);
        end else begin
            passed++;
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ctrl_out !== 3'b111) begin
            $display("FAIL table_cleared: done=%b busy=%b ctrl=%b, want 1 0 111", done, busy, ctrl_out);
        end else begin
            passed++;
        end
    endtask

    task automatic test_saturation();
        repeat (40) @(negedge clk);
        checks++;
        if (sat_cycle_count !== 4'd15) begin
            $display("FAIL saturation: got %0d, want 15", sat_cycle_count);
        end else begin
            passed++;
        end
        repeat (13) @(negedge clk);
        checks++;
        if (sat_cycle_count !== 4'd15) begin
            $display("FAIL saturation_hold: got %0d, want 15", sat_cycle_count);
        end else begin
            passed++;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_three_switch();
        test_zero_deltas();
        test_abort();
        test_table_full();
        test_start_abort_idle();
        test_rst_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
